// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types for the data-memory arbiter:
//   state_t  - arbiter FSM state (core priority / loader lock)
//   owner_t  - which port a pending read response belongs to
//   cnt_width() - width of a saturating counter for a given maximum value
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic {
        S_CORE = 1'b0,   // core has priority, loader wins only when starved
        S_LOCK = 1'b1    // loader owns the memory for a locked burst
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_LD   = 1'b1
    } owner_t;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that saturates at MAX. Clear has priority over increment.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (count -> 0)
//   inc        - count up by one unless already at MAX
//   clr        - force count to zero
//   count      - current value
// -----------------------------------------------------------------------------
module sat_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != MAX_V)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates a single-port synchronous data RAM (one-cycle read latency)
// between the pipeline MEM stage (core) and a loader.
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   core_req/we/addr/wdata          - core access request
//   core_gnt/stall/rvalid/rdata     - core grant, stall, read response
//   ld_req/we/lock/addr/wdata       - loader request; ld_lock holds the memory
//   ld_gnt/rvalid/rdata             - loader grant and read response
//   mem_en/we/addr/wdata, mem_rdata - RAM port
//   state_dbg, starve_cnt_dbg       - FSM state and starvation count
//
// Handshake: a request is accepted in the same cycle its grant is high
// (req & gnt); an ungranted request must be held. A granted read returns
// its data with the owner's rvalid exactly one cycle later, for one cycle.
//
// Arbitration:
//   S_CORE: core wins ties unless the loader has been denied STARVE_MAX
//           consecutive cycles. A loader grant with ld_lock moves to S_LOCK.
//   S_LOCK: loader is granted whenever it requests, core never. The first
//           cycle with ld_lock low arbitrates exactly like S_CORE, so the
//           core can be granted in the release cycle itself.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N          = 32,
    parameter int AW         = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic                            core_req,
    input  logic                            core_we,
    input  logic [AW-1:0]                   core_addr,
    input  logic [N-1:0]                    core_wdata,
    output logic                            core_gnt,
    output logic                            core_stall,
    output logic                            core_rvalid,
    output logic [N-1:0]                    core_rdata,

    input  logic                            ld_req,
    input  logic                            ld_we,
    input  logic                            ld_lock,
    input  logic [AW-1:0]                   ld_addr,
    input  logic [N-1:0]                    ld_wdata,
    output logic                            ld_gnt,
    output logic                            ld_rvalid,
    output logic [N-1:0]                    ld_rdata,

    output logic                            mem_en,
    output logic                            mem_we,
    output logic [AW-1:0]                   mem_addr,
    output logic [N-1:0]                    mem_wdata,
    input  logic [N-1:0]                    mem_rdata,

    output logic                            state_dbg,
    output logic [cnt_width(STARVE_MAX)-1:0] starve_cnt_dbg
);

    localparam int             CW          = cnt_width(STARVE_MAX);
    localparam logic [CW-1:0]  STARVE_FULL = CW'(STARVE_MAX);

    state_t        state_q, state_d;
    owner_t        owner_q;
    logic          rvalid_q;
    logic [CW-1:0] starve_cnt;
    logic          arb_free;
    logic          starve_full;
    logic          gnt_c, gnt_l;

    // ------------------------------------------------------------------
    // Grant decision (combinational, same cycle as the request).
    // Grants are qualified with rst_n so nothing reaches the RAM while
    // reset is held, independent of the registered state.
    // ------------------------------------------------------------------
    always_comb begin
        arb_free    = (state_q == S_CORE) || !ld_lock;
        starve_full = (starve_cnt == STARVE_FULL);
        gnt_c       = 1'b0;
        gnt_l       = 1'b0;
        if (rst_n) begin
            if (arb_free) begin
                gnt_l = ld_req & (~core_req | starve_full);
                gnt_c = core_req & ~gnt_l;
            end else begin
                gnt_l = ld_req;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (arb_free) begin
            state_d = (gnt_l && ld_lock) ? S_LOCK : S_CORE;
        end
    end

    // ------------------------------------------------------------------
    // RAM port mux; all-zero when idle.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_l) begin
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (gnt_c) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Loader starvation counter.
    // ------------------------------------------------------------------
    sat_counter #(
        .MAX (STARVE_MAX),
        .W   (CW)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ld_req & ~gnt_l),
        .clr   (gnt_l),
        .count (starve_cnt)
    );

    // ------------------------------------------------------------------
    // State and read-response tracking. The owner register only moves on
    // a grant; rvalid_q decides whether it is meaningful.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_CORE;
            rvalid_q <= 1'b0;
            owner_q  <= OWN_CORE;
        end else begin
            state_q  <= state_d;
            rvalid_q <= (gnt_c | gnt_l) & ~mem_we;
            if (gnt_c | gnt_l) begin
                owner_q <= gnt_l ? OWN_LD : OWN_CORE;
            end
        end
    end

    assign core_gnt    = gnt_c;
    assign ld_gnt      = gnt_l;
    assign mem_en      = gnt_c | gnt_l;
    assign core_stall  = core_req & ~gnt_c & rst_n;

    assign core_rvalid = rvalid_q & (owner_q == OWN_CORE);
    assign ld_rvalid   = rvalid_q & (owner_q == OWN_LD);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign ld_rdata    = ld_rvalid   ? mem_rdata : '0;

    assign state_dbg      = state_q;
    assign starve_cnt_dbg = starve_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed table of per-cycle vectors (inputs + hand-computed outputs) plus
// hand-written reset sequences. A small RAM model with one-cycle read
// latency sits on the memory port.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int N  = 32;
    localparam int AW = 10;
    localparam int SM = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [N-1:0]  core_wdata;
    logic          core_gnt, core_stall, core_rvalid;
    logic [N-1:0]  core_rdata;
    logic          ld_req, ld_we, ld_lock;
    logic [AW-1:0] ld_addr;
    logic [N-1:0]  ld_wdata;
    logic          ld_gnt, ld_rvalid;
    logic [N-1:0]  ld_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata;
    logic [N-1:0]  mem_rdata;
    logic          state_dbg;
    logic [CW-1:0] starve_cnt_dbg;

    dmem_arbiter #(.N(N), .AW(AW), .STARVE_MAX(SM)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_req       (core_req),
        .core_we        (core_we),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_gnt       (core_gnt),
        .core_stall     (core_stall),
        .core_rvalid    (core_rvalid),
        .core_rdata     (core_rdata),
        .ld_req         (ld_req),
        .ld_we          (ld_we),
        .ld_lock        (ld_lock),
        .ld_addr        (ld_addr),
        .ld_wdata       (ld_wdata),
        .ld_gnt         (ld_gnt),
        .ld_rvalid      (ld_rvalid),
        .ld_rdata       (ld_rdata),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .state_dbg      (state_dbg),
        .starve_cnt_dbg (starve_cnt_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- RAM model ----------------
    logic [N-1:0] ram [0:1023];
    bit           wr_flag [0:1023];

    function automatic logic [N-1:0] init_val(input logic [AW-1:0] a);
        case (a)
            10'h010: return 32'hDEAD_BEEF;
            10'h001: return 32'hA1A1_A1A1;
            10'h002: return 32'hB2B2_B2B2;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]     <= mem_wdata;
                wr_flag[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= wr_flag[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic          cr, cw;
        logic [AW-1:0] ca;
        logic [N-1:0]  cd;
        logic          lr, lw, ll;
        logic [AW-1:0] la;
        logic [N-1:0]  ld;
        logic          cg, lg, cs, me, mw;
        logic [AW-1:0] ma;
        logic [N-1:0]  md;
        logic          crv;
        logic [N-1:0]  crd;
        logic          lrv;
        logic [N-1:0]  lrd;
        logic          st;
        logic [CW-1:0] sc;
    } vec_t;

    vec_t vq[$];
    vec_t cur;

    int n_cmp = 0;
    int n_err = 0;

    task automatic vin(input logic cr, cw, input logic [AW-1:0] ca, input logic [N-1:0] cd,
                       input logic lr, lw, ll, input logic [AW-1:0] la, input logic [N-1:0] ld);
        cur.cr = cr; cur.cw = cw; cur.ca = ca; cur.cd = cd;
        cur.lr = lr; cur.lw = lw; cur.ll = ll; cur.la = la; cur.ld = ld;
    endtask

    task automatic vexp(input logic cg, lg, cs, me, mw, input logic [AW-1:0] ma,
                        input logic [N-1:0] md, input logic crv, input logic [N-1:0] crd,
                        input logic lrv, input logic [N-1:0] lrd, input logic st,
                        input logic [CW-1:0] sc);
        cur.cg = cg; cur.lg = lg; cur.cs = cs; cur.me = me; cur.mw = mw;
        cur.ma = ma; cur.md = md; cur.crv = crv; cur.crd = crd;
        cur.lrv = lrv; cur.lrd = lrd; cur.st = st; cur.sc = sc;
        vq.push_back(cur);
    endtask

    task automatic idle_in();
        vin(0, 0, 10'h000, 32'h0, 0, 0, 0, 10'h000, 32'h0);
    endtask

    // ---------------- driver / checker ----------------
    task automatic drive(input vec_t v);
        core_req = v.cr; core_we = v.cw; core_addr = v.ca; core_wdata = v.cd;
        ld_req = v.lr; ld_we = v.lw; ld_lock = v.ll; ld_addr = v.la; ld_wdata = v.ld;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ctl bits: {core_gnt, ld_gnt, core_stall, mem_en, mem_we, core_rvalid, ld_rvalid, state, starve}
    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("row%0d ctl", i),
            64'({core_gnt, ld_gnt, core_stall, mem_en, mem_we, core_rvalid, ld_rvalid,
                 state_dbg, starve_cnt_dbg}),
            64'({v.cg, v.lg, v.cs, v.me, v.mw, v.crv, v.lrv, v.st, v.sc}));
        chk($sformatf("row%0d mem_addr", i),   64'(mem_addr),   64'(v.ma));
        chk($sformatf("row%0d mem_wdata", i),  64'(mem_wdata),  64'(v.md));
        chk($sformatf("row%0d core_rdata", i), 64'(core_rdata), 64'(v.crd));
        chk($sformatf("row%0d ld_rdata", i),   64'(ld_rdata),   64'(v.lrd));
    endtask

    // ---------------- test ----------------
    initial begin
        rst_n = 1'b0;
        idle_in();
        drive(cur);

        // Table. Each row: inputs for one cycle, then outputs seen in that
        // cycle (rvalid/rdata belong to the previous cycle's grant; state and
        // starve are the register values before the coming edge).
        // R0 idle
        idle_in();                                               vexp(0,0,0,0,0,10'h000,0, 0,0,0,0, 0,0);
        // R1 core read 0x010, R2 response, R3 response gone
        vin(1,0,10'h010,0, 0,0,0,10'h000,0);                     vexp(1,0,0,1,0,10'h010,0, 0,0,0,0, 0,0);
        idle_in();                                               vexp(0,0,0,0,0,10'h000,0, 1,32'hDEADBEEF,0,0, 0,0);
        idle_in();                                               vexp(0,0,0,0,0,10'h000,0, 0,0,0,0, 0,0);
        // R4-R9 both requesting: core x4, loader on 5th, core again
        vin(1,0,10'h001,0, 1,0,0,10'h002,0);                     vexp(1,0,0,1,0,10'h001,0, 0,0,0,0, 0,0);
        vin(1,0,10'h001,0, 1,0,0,10'h002,0);                     vexp(1,0,0,1,0,10'h001,0, 1,32'hA1A1A1A1,0,0, 0,1);
        vin(1,0,10'h001,0, 1,0,0,10'h002,0);                     vexp(1,0,0,1,0,10'h001,0, 1,32'hA1A1A1A1,0,0, 0,2);
        vin(1,0,10'h001,0, 1,0,0,10'h002,0);                     vexp(1,0,0,1,0,10'h001,0, 1,32'hA1A1A1A1,0,0, 0,3);
        vin(1,0,10'h001,0, 1,0,0,10'h002,0);                     vexp(0,1,1,1,0,10'h002,0, 1,32'hA1A1A1A1,0,0, 0,4);
        vin(1,0,10'h001,0, 1,0,0,10'h002,0);                     vexp(1,0,0,1,0,10'h001,0, 0,0,1,32'hB2B2B2B2, 0,0);
        // R10-R11 idle: count holds at 1
        idle_in();                                               vexp(0,0,0,0,0,10'h000,0, 1,32'hA1A1A1A1,0,0, 0,1);
        idle_in();                                               vexp(0,0,0,0,0,10'h000,0, 0,0,0,0, 0,1);
        // R12-R13 loader-only read clears the count
        vin(0,0,10'h000,0, 1,0,0,10'h002,0);                     vexp(0,1,0,1,0,10'h002,0, 0,0,0,0, 0,1);
        idle_in();                                               vexp(0,0,0,0,0,10'h000,0, 0,0,1,32'hB2B2B2B2, 0,0);
        // R14-R18 alternating owners, back to back
        vin(1,0,10'h001,0, 0,0,0,10'h000,0);                     vexp(1,0,0,1,0,10'h001,0, 0,0,0,0, 0,0);
        vin(0,0,10'h000,0, 1,0,0,10'h002,0);                     vexp(0,1,0,1,0,10'h002,0, 1,32'hA1A1A1A1,0,0, 0,0);
        vin(1,0,10'h001,0, 0,0,0,10'h000,0);                     vexp(1,0,0,1,0,10'h001,0, 0,0,1,32'hB2B2B2B2, 0,0);
        vin(0,0,10'h000,0, 1,0,0,10'h002,0);                     vexp(0,1,0,1,0,10'h002,0, 1,32'hA1A1A1A1,0,0, 0,0);
        idle_in();                                               vexp(0,0,0,0,0,10'h000,0, 0,0,1,32'hB2B2B2B2, 0,0);
        // R19-R21 core write (no rvalid), then read back
        vin(1,1,10'h020,32'h55AA55AA, 0,0,0,10'h000,0);          vexp(1,0,0,1,1,10'h020,32'h55AA55AA, 0,0,0,0, 0,0);
        vin(1,0,10'h020,0, 0,0,0,10'h000,0);                     vexp(1,0,0,1,0,10'h020,0, 0,0,0,0, 0,0);
        idle_in();                                               vexp(0,0,0,0,0,10'h000,0, 1,32'h55AA55AA,0,0, 0,0);
        // R22-R27 locked loader write, core stalled 3 cycles, released
        vin(0,0,10'h000,0, 1,1,1,10'h3FF,32'h12345678);          vexp(0,1,0,1,1,10'h3FF,32'h12345678, 0,0,0,0, 0,0);
        vin(1,0,10'h001,0, 0,0,1,10'h000,0);                     vexp(0,0,1,0,0,10'h000,0, 0,0,0,0, 1,0);
        vin(1,0,10'h001,0, 1,1,1,10'h3FE,32'h0000CAFE);          vexp(0,1,1,1,1,10'h3FE,32'h0000CAFE, 0,0,0,0, 1,0);
        vin(1,0,10'h001,0, 0,0,1,10'h000,0);                     vexp(0,0,1,0,0,10'h000,0, 0,0,0,0, 1,0);
        vin(1,0,10'h001,0, 0,0,0,10'h000,0);                     vexp(1,0,0,1,0,10'h001,0, 0,0,0,0, 1,0);
        idle_in();                                               vexp(0,0,0,0,0,10'h000,0, 1,32'hA1A1A1A1,0,0, 0,0);
        // R28-R29 loader reads back its locked write
        vin(0,0,10'h000,0, 1,0,0,10'h3FF,0);                     vexp(0,1,0,1,0,10'h3FF,0, 0,0,0,0, 0,0);
        idle_in();                                               vexp(0,0,0,0,0,10'h000,0, 0,0,1,32'h12345678, 0,0);
        // R30-R31 denied locked loader request does not lock
        vin(1,0,10'h001,0, 1,0,1,10'h3FE,0);                     vexp(1,0,0,1,0,10'h001,0, 0,0,0,0, 0,0);
        idle_in();                                               vexp(0,0,0,0,0,10'h000,0, 1,32'hA1A1A1A1,0,0, 0,1);

        // ---- reset held: requests present, everything stays quiet ----
        #2;
        vin(1,1,10'h155,32'hFFFFFFFF, 1,1,1,10'h2AA,32'hFFFFFFFF);
        drive(cur);
        #1;
        chk("rst ctl", 64'({core_gnt, ld_gnt, core_stall, mem_en, mem_we, core_rvalid, ld_rvalid,
                            state_dbg, starve_cnt_dbg}), 64'h0);
        chk("rst mem_addr",  64'(mem_addr),  64'h0);
        chk("rst mem_wdata", 64'(mem_wdata), 64'h0);
        chk("rst rdata",     64'({core_rdata, ld_rdata}), 64'h0);
        @(negedge clk);
        idle_in();
        drive(cur);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            #2;
            check_vec(i, vq[i]);
        end

        // ---- reset during a granted read ----
        // count is 1 after R31; one more denied cycle makes it 2
        @(negedge clk);
        vin(1,0,10'h010,0, 1,0,0,10'h002,0);
        drive(cur);
        @(negedge clk);
        vin(1,0,10'h010,0, 0,0,0,10'h000,0);
        drive(cur);
        #2;
        chk("midrd gnt", 64'({core_gnt, ld_gnt, starve_cnt_dbg}), 64'({1'b1, 1'b0, 3'd2}));
        #1 rst_n = 1'b0;
        #1;
        chk("midrd in-reset ctl", 64'({core_gnt, core_stall, mem_en, state_dbg, starve_cnt_dbg}), 64'h0);
        chk("midrd in-reset addr", 64'(mem_addr), 64'h0);
        @(negedge clk);
        idle_in();
        drive(cur);
        rst_n = 1'b1;
        #2;
        chk("midrd post-rst rvalid", 64'({core_rvalid, ld_rvalid, core_rdata}), 64'h0);
        @(negedge clk);
        #2;
        chk("midrd post-rst idle", 64'({core_rvalid, ld_rvalid, mem_en, state_dbg, starve_cnt_dbg}), 64'h0);

        // ---- grant on the first cycle after reset release ----
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vin(1,0,10'h010,0, 0,0,0,10'h000,0);
        drive(cur);
        rst_n = 1'b1;
        #2;
        chk("first gnt", 64'({core_gnt, core_stall, mem_en, mem_addr}), 64'({1'b1, 1'b0, 1'b1, 10'h010}));
        @(negedge clk);
        idle_in();
        drive(cur);
        #2;
        chk("first rd data", 64'({core_rvalid, ld_rvalid, core_rdata}), 64'({1'b1, 1'b0, 32'hDEADBEEF}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
